// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared types and encodings for the multi-cycle MIPS control FSM.
// Holds the FSM state enum, ALU operation codes, opcode/funct values,
// datapath mux encodings and the decoded-instruction struct.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXE     = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_MEM  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_e;

  // Instruction class selects the path taken out of DECODE.
  typedef enum logic [2:0] {
    CL_ILL = 3'd0,
    CL_ALU = 3'd1,
    CL_MEM = 3'd2,
    CL_BR  = 3'd3,
    CL_JMP = 3'd4
  } cls_e;

  // Branch condition: which ALU flag qualifies pc_we in BRANCH.
  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NE  = 2'd1,
    BR_LEZ = 2'd2,
    BR_GTZ = 2'd3
  } br_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SRLV = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_RS  = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_DM   = 2'd1;
  localparam logic [1:0] M2R_LESS = 2'd2;
  localparam logic [1:0] M2R_PC   = 2'd3;

  localparam logic [1:0] SB_RT   = 2'd0;
  localparam logic [1:0] SB_SEXT = 2'd1;
  localparam logic [1:0] SB_ZEXT = 2'd2;
  localparam logic [1:0] SB_LUI  = 2'd3;

  typedef struct packed {
    cls_e       cls;
    logic       is_lw;
    logic       is_jal;
    logic       is_jr;
    br_e        br;
    logic [2:0] aluop;
    logic       sltiu;
    logic       sltu;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } dec_t;

endpackage

// File: rtl/mips_mc_decode.sv
// mips_mc_decode: combinational opcode/funct decoder for the multi-cycle control.
// Latency: zero (pure combinational). No flow control.
// Ports: i_opcode/i_funct from the IR; o_dec carries class plus per-instruction
// ALU/mux settings used in EXE/WB_ALU and the branch/jump qualifiers.
module mips_mc_decode
  import mips_mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] i_opcode,
  input  logic [OP_W-1:0] i_funct,
  output dec_t            o_dec
);

  always_comb begin
    o_dec     = '0;
    o_dec.cls = CL_ILL;
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.reg_dst   = RD_RD;
        o_dec.alu_src_b = SB_RT;
        case (i_funct)
          FN_ADDU: begin o_dec.cls = CL_ALU; o_dec.aluop = ALU_ADD; end
          FN_SUBU: begin o_dec.cls = CL_ALU; o_dec.aluop = ALU_SUB; end
          FN_SLT: begin
            o_dec.cls        = CL_ALU;
            o_dec.aluop      = ALU_SUB;
            o_dec.mem_to_reg = M2R_LESS;
          end
          FN_SLTU: begin
            o_dec.cls        = CL_ALU;
            o_dec.aluop      = ALU_SUB;
            o_dec.sltu       = 1'b1;
            o_dec.mem_to_reg = M2R_LESS;
          end
          FN_SRL:  begin o_dec.cls = CL_ALU; o_dec.aluop = ALU_SRL; end
          FN_SRLV: begin o_dec.cls = CL_ALU; o_dec.aluop = ALU_SRLV; end
          FN_JR:   begin o_dec.cls = CL_JMP; o_dec.is_jr = 1'b1; end
          default: ;
        endcase
      end
      OP_ORI: begin
        o_dec.cls       = CL_ALU;
        o_dec.aluop     = ALU_OR;
        o_dec.alu_src_b = SB_ZEXT;
      end
      OP_LUI: begin
        // lui computes 0 + (imm<<16) through the adder.
        o_dec.cls       = CL_ALU;
        o_dec.aluop     = ALU_ADD;
        o_dec.alu_src_b = SB_LUI;
      end
      OP_SLTIU: begin
        o_dec.cls        = CL_ALU;
        o_dec.aluop      = ALU_SUB;
        o_dec.sltiu      = 1'b1;
        o_dec.alu_src_b  = SB_ZEXT;
        o_dec.mem_to_reg = M2R_LESS;
      end
      OP_LW:   begin o_dec.cls = CL_MEM; o_dec.is_lw = 1'b1; end
      OP_SW:   o_dec.cls = CL_MEM;
      OP_BEQ:  begin o_dec.cls = CL_BR; o_dec.br = BR_EQ; end
      OP_BNE:  begin o_dec.cls = CL_BR; o_dec.br = BR_NE; end
      OP_BLEZ: begin o_dec.cls = CL_BR; o_dec.br = BR_LEZ; end
      OP_BGTZ: begin o_dec.cls = CL_BR; o_dec.br = BR_GTZ; end
      OP_J:    o_dec.cls = CL_JMP;
      OP_JAL:  begin o_dec.cls = CL_JMP; o_dec.is_jal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control FSM driving the shared p5 datapath.
// Latency: CPI 4 for ALU ops and sw, 5 for lw, 3 for branch/jump; outputs decode
// from the state register (pc_we in BRANCH also depends on the ALU flags).
// Ports: opcode/funct from IR, alu_* compare flags in; ALU controls, mux selects,
// write enables, illegal pulse and state_o out. Optional MIPS_MC_CTRL_PERF_EN
// adds instr_cnt/cyc_cnt performance counters.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            alu_zero,
  input  logic            alu_ne,
  input  logic            alu_g,
  input  logic            alu_le,
  output logic [2:0]      aluop,
  output logic            sltiu,
  output logic            sltu,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            ir_we,
  output logic            mem_we,
  output logic            reg_we,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic [1:0]      alu_src_b,
  output logic            illegal,
  output logic [ST_W-1:0] state_o
`ifdef MIPS_MC_CTRL_PERF_EN
  ,
  output logic [31:0]     instr_cnt,
  output logic [31:0]     cyc_cnt
`endif
);

  state_e r_state;
  dec_t   w_dec;
  logic   w_br_take;

  mips_mc_decode #(.OP_W(OP_W)) u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_dec    (w_dec)
  );

  assign w_br_take = (w_dec.br == BR_EQ)  ? alu_zero :
                     (w_dec.br == BR_NE)  ? alu_ne   :
                     (w_dec.br == BR_LEZ) ? alu_le   : alu_g;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (w_dec.cls)
            CL_ALU:  r_state <= S_EXE;
            CL_MEM:  r_state <= S_MEM_ADR;
            CL_BR:   r_state <= S_BRANCH;
            CL_JMP:  r_state <= S_JUMP;
            default: r_state <= S_FETCH;  // illegal: skip straight to next fetch
          endcase
        end
        S_EXE:     r_state <= S_WB_ALU;
        S_MEM_ADR: r_state <= w_dec.is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  r_state <= S_WB_MEM;
        S_WB_ALU, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        default:   r_state <= S_IDLE;     // unused encodings recover
      endcase
    end
  end

`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] r_instr_cnt;
  logic [31:0] r_cyc_cnt;

  // An instruction retires on any state that returns to FETCH; the illegal
  // path leaves from DECODE and is deliberately not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_cnt <= 32'd0;
      r_cyc_cnt   <= 32'd0;
    end else begin
      if (r_state != S_IDLE)
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (r_state inside {S_WB_ALU, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP})
        r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign cyc_cnt   = r_cyc_cnt;
`endif

  // Outputs decode from r_state so an async reset clears every enable at once.
  always_comb begin
    aluop      = ALU_ADD;
    sltiu      = 1'b0;
    sltu       = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SEQ;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    alu_src_b  = SB_RT;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_DECODE: illegal = (w_dec.cls == CL_ILL);
      S_EXE, S_WB_ALU: begin
        // ALU controls stay up through write-back so the result is stable.
        aluop     = w_dec.aluop;
        sltiu     = w_dec.sltiu;
        sltu      = w_dec.sltu;
        alu_src_b = w_dec.alu_src_b;
        if (r_state == S_WB_ALU) begin
          reg_we     = 1'b1;
          reg_dst    = w_dec.reg_dst;
          mem_to_reg = w_dec.mem_to_reg;
        end
      end
      S_MEM_ADR: begin
        aluop     = ALU_ADD;
        alu_src_b = SB_SEXT;
      end
      S_MEM_WR: mem_we = 1'b1;
      S_WB_MEM: begin
        reg_we     = 1'b1;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_DM;
      end
      S_BRANCH: begin
        aluop     = ALU_SUB;
        alu_src_b = SB_RT;
        pc_src    = PC_BR;
        pc_we     = w_br_take;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = w_dec.is_jr ? PC_RS : PC_JMP;
        if (w_dec.is_jal) begin
          // PC already advanced in FETCH, so it is the link value.
          reg_we     = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = M2R_PC;
        end
      end
      default: ;
    endcase
  end

  assign state_o = ST_W'(r_state);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed bench for mips_mc_ctrl with an instruction-level
// model (state sequence from CPI class, outputs from per-state rules) compared
// on every falling edge, plus literal checks on recorded cycles.
module tb_mips_mc_ctrl;

  localparam int I_ADDU = 0, I_SUBU = 1, I_SLT = 2, I_SLTU = 3, I_SRL = 4,
                 I_SRLV = 5, I_JR = 6, I_ORI = 7, I_LUI = 8, I_SLTIU = 9,
                 I_LW = 10, I_SW = 11, I_BEQ = 12, I_BNE = 13, I_BLEZ = 14,
                 I_BGTZ = 15, I_J = 16, I_JAL = 17, I_ILL = 18;

  typedef struct packed {
    logic [2:0] aluop;
    logic       sltiu;
    logic       sltu;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       alu_zero = 1'b0, alu_ne = 1'b0, alu_g = 1'b0, alu_le = 1'b0;
  logic [2:0] aluop;
  logic       sltiu, sltu, pc_we, ir_we, mem_we, reg_we, illegal;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [3:0] state_o;
`ifdef MIPS_MC_CTRL_PERF_EN
  logic [31:0] instr_cnt, cyc_cnt;
`endif
  ctl_t dut_ctl;

  int n_chk = 0;
  int n_fail = 0;
  bit m_valid = 1'b0;
  int m_state = 0;
  int m_id = I_ILL;

  int         rec_state [5];
  logic       rec_irwe [5], rec_pcwe [5], rec_memwe [5], rec_regwe [5];
  logic       rec_sltiu [5], rec_illegal [5];
  logic [2:0] rec_aluop [5];
  logic [1:0] rec_pcsrc [5], rec_regdst [5], rec_m2r [5], rec_srcb [5];

  always #5 clk = ~clk;

  mips_mc_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_ne(alu_ne), .alu_g(alu_g), .alu_le(alu_le),
    .aluop(aluop), .sltiu(sltiu), .sltu(sltu), .pc_we(pc_we), .pc_src(pc_src),
    .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .illegal(illegal),
    .state_o(state_o)
`ifdef MIPS_MC_CTRL_PERF_EN
    , .instr_cnt(instr_cnt), .cyc_cnt(cyc_cnt)
`endif
  );

  assign dut_ctl = {aluop, sltiu, sltu, pc_we, pc_src, ir_we, mem_we, reg_we,
                    reg_dst, mem_to_reg, alu_src_b, illegal};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int ident(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: begin
        case (fn)
          6'h21: return I_ADDU;
          6'h23: return I_SUBU;
          6'h2A: return I_SLT;
          6'h2B: return I_SLTU;
          6'h02: return I_SRL;
          6'h06: return I_SRLV;
          6'h08: return I_JR;
          default: return I_ILL;
        endcase
      end
      6'h0D: return I_ORI;
      6'h0F: return I_LUI;
      6'h0B: return I_SLTIU;
      6'h23: return I_LW;
      6'h2B: return I_SW;
      6'h04: return I_BEQ;
      6'h05: return I_BNE;
      6'h06: return I_BLEZ;
      6'h07: return I_BGTZ;
      6'h02: return I_J;
      6'h03: return I_JAL;
      default: return I_ILL;
    endcase
  endfunction

  // Cycles per instruction; illegal costs FETCH + DECODE only.
  function automatic int cpi(input int id);
    if (id == I_LW) return 5;
    if (id == I_SW) return 4;
    if ((id >= I_BEQ && id <= I_BGTZ) || id == I_J || id == I_JAL || id == I_JR) return 3;
    if (id == I_ILL) return 2;
    return 4;
  endfunction

  function automatic int seq_state(input int id, input int k);
    int s [5];
    s = '{1, 2, 0, 0, 0};
    if (id == I_LW) s = '{1, 2, 4, 5, 8};
    else if (id == I_SW) s = '{1, 2, 4, 6, 0};
    else if (id >= I_BEQ && id <= I_BGTZ) s = '{1, 2, 9, 0, 0};
    else if (id == I_J || id == I_JAL || id == I_JR) s = '{1, 2, 10, 0, 0};
    else if (id != I_ILL) s = '{1, 2, 3, 7, 0};
    return s[k];
  endfunction

  function automatic ctl_t model(input int st, input int id, input logic z,
                                 input logic ne, input logic g, input logic le);
    ctl_t c;
    bit   r_type, is_less;
    c       = '0;
    r_type  = (id <= I_SRLV);
    is_less = (id == I_SLT) || (id == I_SLTU) || (id == I_SLTIU);
    case (st)
      1: begin c.ir_we = 1'b1; c.pc_we = 1'b1; end
      2: c.illegal = (id == I_ILL);
      3, 7: begin
        if (id == I_ADDU || id == I_LUI) c.aluop = 3'b000;
        else if (id == I_ORI)            c.aluop = 3'b010;
        else if (id == I_SRL)            c.aluop = 3'b101;
        else if (id == I_SRLV)           c.aluop = 3'b100;
        else                             c.aluop = 3'b001;
        c.sltiu     = (id == I_SLTIU);
        c.sltu      = (id == I_SLTU);
        c.alu_src_b = r_type ? 2'd0 : (id == I_LUI) ? 2'd3 : 2'd2;
        if (st == 7) begin
          c.reg_we     = 1'b1;
          c.reg_dst    = r_type ? 2'd1 : 2'd0;
          c.mem_to_reg = is_less ? 2'd2 : 2'd0;
        end
      end
      4: begin c.aluop = 3'b000; c.alu_src_b = 2'd1; end
      6: c.mem_we = 1'b1;
      8: begin c.reg_we = 1'b1; c.mem_to_reg = 2'd1; end
      9: begin
        c.aluop  = 3'b001;
        c.pc_src = 2'd1;
        c.pc_we  = (id == I_BEQ) ? z : (id == I_BNE) ? ne : (id == I_BLEZ) ? le : g;
      end
      10: begin
        c.pc_we  = 1'b1;
        c.pc_src = (id == I_JR) ? 2'd3 : 2'd2;
        if (id == I_JAL) begin
          c.reg_we     = 1'b1;
          c.reg_dst    = 2'd2;
          c.mem_to_reg = 2'd3;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk($sformatf("state id=%0d", m_id), 32'(state_o), 32'(m_state));
      chk($sformatf("ctl id=%0d st=%0d", m_id, m_state), 32'(dut_ctl),
          32'(model(m_state, m_id, alu_zero, alu_ne, alu_g, alu_le)));
    end
  end

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ne, input logic g,
                           input logic le, input bit abort_last);
    int id, n;
    id = ident(op, fn);
    n  = cpi(id);
    opcode = op; funct = fn;
    alu_zero = z; alu_ne = ne; alu_g = g; alu_le = le;
    m_id = id;
    for (int k = 0; k < n; k++) begin
      m_state = seq_state(id, k);
      #2;
      rec_state[k]   = int'(state_o);
      rec_irwe[k]    = ir_we;
      rec_pcwe[k]    = pc_we;
      rec_memwe[k]   = mem_we;
      rec_regwe[k]   = reg_we;
      rec_sltiu[k]   = sltiu;
      rec_illegal[k] = illegal;
      rec_aluop[k]   = aluop;
      rec_pcsrc[k]   = pc_src;
      rec_regdst[k]  = reg_dst;
      rec_m2r[k]     = mem_to_reg;
      rec_srcb[k]    = alu_src_b;
      if (abort_last && k == n - 1) return;
      @(posedge clk); #1;
    end
  endtask

  // Assert reset (checked asynchronously), hold n edges, release, leave one IDLE cycle.
  task automatic do_reset(input int n);
    reset = 1'b1;
    m_state = 0;
    m_id = I_ILL;
    #1;
    chk("rst_async_state", 32'(state_o), 32'd0);
    chk("rst_async_ctl", 32'(dut_ctl), 32'd0);
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("rel_idle_state", 32'(state_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    @(posedge clk); #1;
    m_valid = 1'b1;
    do_reset(2);

    run_instr(6'h00, 6'h21, 0, 0, 0, 0, 0);  // addu
    chk("first_fetch_irwe", 32'(rec_irwe[0]), 32'd1);
    chk("first_fetch_pcwe", 32'(rec_pcwe[0]), 32'd1);
    chk("addu_exe_state", 32'(rec_state[2]), 32'd3);
    chk("addu_exe_aluop", 32'(rec_aluop[2]), 32'd0);
    chk("addu_exe_regwe", 32'(rec_regwe[2]), 32'd0);
    chk("addu_wb_regwe", 32'(rec_regwe[3]), 32'd1);
    chk("addu_wb_regdst", 32'(rec_regdst[3]), 32'd1);

    run_instr(6'h00, 6'h23, 0, 0, 0, 0, 0);  // subu
    run_instr(6'h00, 6'h2A, 0, 0, 0, 0, 0);  // slt
    run_instr(6'h00, 6'h2B, 0, 0, 0, 0, 0);  // sltu
    run_instr(6'h00, 6'h02, 0, 0, 0, 0, 0);  // srl
    run_instr(6'h00, 6'h06, 0, 0, 0, 0, 0);  // srlv
    run_instr(6'h0D, 6'h00, 0, 0, 0, 0, 0);  // ori
    run_instr(6'h0F, 6'h00, 0, 0, 0, 0, 0);  // lui
    run_instr(6'h0B, 6'h15, 0, 0, 0, 0, 0);  // sltiu
    chk("sltiu_exe_aluop", 32'(rec_aluop[2]), 32'd1);
    chk("sltiu_exe_sel", 32'(rec_sltiu[2]), 32'd1);
    chk("sltiu_exe_srcb", 32'(rec_srcb[2]), 32'd2);
    chk("sltiu_wb_m2r", 32'(rec_m2r[3]), 32'd2);

    run_instr(6'h23, 6'h00, 0, 0, 0, 0, 0);  // lw
    chk("lw_rd_state", 32'(rec_state[3]), 32'd5);
    chk("lw_wbmem_state", 32'(rec_state[4]), 32'd8);
    chk("lw_wbmem_m2r", 32'(rec_m2r[4]), 32'd1);
    chk("lw_wbmem_regwe", 32'(rec_regwe[4]), 32'd1);

    run_instr(6'h2B, 6'h00, 0, 0, 0, 0, 0);  // sw
    cnt = 0;
    for (int k = 0; k < 4; k++) cnt += int'(rec_memwe[k]);
    chk("sw_memwe_cycles", 32'(cnt), 32'd1);
    chk("sw_memwr_state", 32'(rec_state[3]), 32'd6);

    run_instr(6'h04, 6'h00, 1, 0, 0, 1, 0);  // beq taken
    chk("beq_t_pcwe", 32'(rec_pcwe[2]), 32'd1);
    chk("beq_t_pcsrc", 32'(rec_pcsrc[2]), 32'd1);
    run_instr(6'h04, 6'h00, 0, 1, 1, 0, 0);  // beq not taken
    chk("beq_nt_pcwe", 32'(rec_pcwe[2]), 32'd0);
    run_instr(6'h05, 6'h00, 0, 1, 0, 1, 0);  // bne taken
    run_instr(6'h06, 6'h00, 0, 1, 0, 1, 0);  // blez taken
    run_instr(6'h07, 6'h00, 0, 1, 0, 1, 0);  // bgtz not taken
    chk("bgtz_nt_pcwe", 32'(rec_pcwe[2]), 32'd0);
    run_instr(6'h07, 6'h00, 0, 1, 1, 0, 0);  // bgtz taken

    run_instr(6'h02, 6'h00, 0, 0, 0, 0, 0);  // j
    run_instr(6'h03, 6'h00, 0, 0, 0, 0, 0);  // jal
    run_instr(6'h00, 6'h08, 0, 0, 0, 0, 0);  // jr

    run_instr(6'h3F, 6'h00, 0, 0, 0, 0, 0);  // illegal opcode
    chk("ill_pulse", 32'(rec_illegal[1]), 32'd1);
    chk("ill_decode_state", 32'(rec_state[1]), 32'd2);
    chk("ill_no_we", 32'({rec_regwe[1], rec_memwe[1], rec_pcwe[1]}), 32'd0);
    run_instr(6'h00, 6'h3F, 0, 0, 0, 0, 0);  // illegal funct
    run_instr(6'h00, 6'h21, 0, 0, 0, 0, 0);
    chk("after_ill_fetch", 32'(rec_state[0]), 32'd1);

    run_instr(6'h2B, 6'h00, 0, 0, 0, 0, 1);  // sw, stopped inside MEM_WR
    chk("abort_memwe_before", 32'(rec_memwe[3]), 32'd1);
    do_reset(1);
    run_instr(6'h0D, 6'h00, 0, 0, 0, 0, 0);  // ori after recovery

    m_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
